// File: rtl/chiplet_types_pkg.sv
// Shared chiplet types: flit format, RX header layout,
// CRC-32 constants and RX checker state encoding.
package chiplet_types_pkg;

  typedef struct packed {
    logic [4:0] req;
  } flit_meta_t;

  typedef struct packed {
    flit_meta_t  metadata;
    logic [31:0] payload;
  } flit_t;

  typedef struct packed {
    logic [3:0]  rsvd_hi;
    logic [4:0]  dest;
    logic [15:0] rsvd_lo;
    logic [6:0]  len;
  } rx_hdr_t;

  localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_PAYLOAD,
    RX_CHECK,
    RX_HOLD
  } rx_state_t;

endpackage

// File: rtl/rx_pkt_checker_if.sv
// Switch port-0 to requestor-FIFO bundle for the RX checker.
// slave = checker side, master = switch/FIFO side.
interface rx_pkt_checker_if;
  import chiplet_types_pkg::*;

  flit_t      in_flit;
  logic       data_ready;
  logic       overflow;
  logic       accept;
  logic       enable;
  logic       crc_valid;
  logic [4:0] req;
  logic [6:0] pkt_words;
  logic       err_dest;
  logic       err_clr;

  modport slave (
    input  in_flit,
    input  data_ready,
    input  overflow,
    input  err_clr,
    output accept,
    output enable,
    output crc_valid,
    output req,
    output pkt_words,
    output err_dest
  );

  modport master (
    output in_flit,
    output data_ready,
    output overflow,
    output err_clr,
    input  accept,
    input  enable,
    input  crc_valid,
    input  req,
    input  pkt_words,
    input  err_dest
  );

endinterface

// File: rtl/crc32_word.sv
// Word-serial CRC-32 step, MSB first, no reflection.
// Shared with the TX side for CRC append.
module crc32_word
  import chiplet_types_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [31:0] data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 31; i >= 0; i--) begin
      if (c[31] ^ data[i])
        c = {c[30:0], 1'b0} ^ CRC32_POLY;
      else
        c = {c[30:0], 1'b0};
    end
  end

  assign crc_out = c;

endmodule

// File: rtl/rx_pkt_checker.sv
// Frames port-0 flits into packets, checks the trailing
// CRC-32 and posts one completion per packet to the FIFO.
module rx_pkt_checker
  import chiplet_types_pkg::*;
#(
  parameter int         MAX_WORDS = 128,
  parameter logic [4:0] NODE_ID   = 5'd0
) (
  input logic             clk,
  input logic             n_rst,
  rx_pkt_checker_if.slave rx
);

  localparam logic [7:0] MAX_W = 8'(MAX_WORDS);

  rx_state_t   state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [7:0]  rem_q, rem_d;
  logic [6:0]  len_q, len_d;
  logic [4:0]  hreq_q, hreq_d;
  logic        en_q, en_d;
  logic        vld_q, vld_d;
  logic [4:0]  oreq_q, oreq_d;
  logic [6:0]  owords_q, owords_d;
  logic        err_q, err_d;

  rx_hdr_t     hdr;
  logic [31:0] crc_seed;
  logic [31:0] crc_nx;
  logic        acc;
  logic        accept_w;
  logic        unused_hdr;

  assign hdr        = rx_hdr_t'(rx.in_flit.payload);
  assign unused_hdr = ^{hdr.rsvd_hi, hdr.rsvd_lo};
  assign accept_w   = (state_q != RX_HOLD);
  assign acc        = rx.data_ready & accept_w;
  assign crc_seed   = (state_q == RX_IDLE) ? CRC32_INIT : crc_q;

  crc32_word u_crc (
    .crc_in  (crc_seed),
    .data    (rx.in_flit.payload),
    .crc_out (crc_nx)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= RX_IDLE;
      crc_q    <= CRC32_INIT;
      rem_q    <= '0;
      len_q    <= '0;
      hreq_q   <= '0;
      en_q     <= 1'b0;
      vld_q    <= 1'b0;
      oreq_q   <= '0;
      owords_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      crc_q    <= crc_d;
      rem_q    <= rem_d;
      len_q    <= len_d;
      hreq_q   <= hreq_d;
      en_q     <= en_d;
      vld_q    <= vld_d;
      oreq_q   <= oreq_d;
      owords_q <= owords_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    crc_d    = crc_q;
    rem_d    = rem_q;
    len_d    = len_q;
    hreq_d   = hreq_q;
    en_d     = 1'b0;
    vld_d    = vld_q;
    oreq_d   = oreq_q;
    owords_d = owords_q;
    // Clear first so a same-cycle dest error wins.
    err_d    = err_q & ~rx.err_clr;
    unique case (state_q)
      RX_IDLE: begin
        if (acc) begin
          crc_d   = crc_nx;
          rem_d   = (hdr.len == 7'd0) ? MAX_W
                                      : {1'b0, hdr.len};
          len_d   = hdr.len;
          hreq_d  = rx.in_flit.metadata.req;
          state_d = RX_PAYLOAD;
          if (hdr.dest != NODE_ID)
            err_d = 1'b1;
        end
      end
      RX_PAYLOAD: begin
        if (acc) begin
          crc_d = crc_nx;
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1)
            state_d = RX_CHECK;
        end
      end
      RX_CHECK: begin
        if (acc) begin
          vld_d    = (rx.in_flit.payload == crc_q);
          oreq_d   = hreq_q;
          owords_d = len_q;
          if (rx.overflow) begin
            state_d = RX_HOLD;
          end else begin
            en_d    = 1'b1;
            state_d = RX_IDLE;
          end
        end
      end
      RX_HOLD: begin
        if (!rx.overflow) begin
          en_d    = 1'b1;
          state_d = RX_IDLE;
        end
      end
    endcase
  end

  assign rx.accept    = accept_w;
  assign rx.enable    = en_q;
  assign rx.crc_valid = vld_q;
  assign rx.req       = oreq_q;
  assign rx.pkt_words = owords_q;
  assign rx.err_dest  = err_q;

endmodule

// File: tb/tb_rx_pkt_checker.sv
// Randomized bench for rx_pkt_checker with a packet-level
// scoreboard predicting each completion's cycle and fields.
module tb_rx_pkt_checker;
  import chiplet_types_pkg::*;

  localparam logic [4:0] NODE = 5'd3;

  typedef struct {
    int         due;
    bit         vld;
    logic [4:0] req;
    logic [6:0] words;
  } exp_t;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  rx_pkt_checker_if rx ();

  rx_pkt_checker #(
    .MAX_WORDS (128),
    .NODE_ID   (NODE)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .rx    (rx)
  );

  exp_t       sb[$];
  bit         lowc[int];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         n_en = 0;
  bit         checking = 0;
  int         ovf_left = 0;
  bit         last_vld;
  logic [4:0] last_req;
  logic [6:0] last_words;
  int         last_hdr_m;
  int         last_crc_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] m_crc_byte(
    logic [31:0] c, logic [7:0] b);
    logic [31:0] r;
    r = c ^ {b, 24'h0};
    for (int i = 0; i < 8; i++)
      r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
    return r;
  endfunction

  function automatic logic [31:0] m_crc_word(
    logic [31:0] c, logic [31:0] w);
    logic [31:0] r;
    r = c;
    for (int b = 3; b >= 0; b--)
      r = m_crc_byte(r, w[8*b +: 8]);
    return r;
  endfunction

  always @(negedge clk) begin : cmp
    bit exp_en;
    if (checking) begin
      exp_en = (sb.size() > 0) && (sb[0].due == cyc);
      chk("enable", rx.enable, exp_en);
      chk("accept", rx.accept, !lowc.exists(cyc));
      if (rx.enable) n_en++;
      if (exp_en) begin
        chk("crc_valid", rx.crc_valid, sb[0].vld);
        chk("req", rx.req, sb[0].req);
        chk("pkt_words", rx.pkt_words, sb[0].words);
        last_vld   = rx.crc_valid;
        last_req   = rx.req;
        last_words = rx.pkt_words;
        void'(sb.pop_front());
      end else if (sb.size() > 0 && sb[0].due < cyc) begin
        chk("enable_cycle", cyc, sb[0].due);
        void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    rx.overflow = (ovf_left > 0);
    if (ovf_left > 0) ovf_left--;
    rx.err_clr = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      tick();
      rx.data_ready = 1'b0;
      rx.in_flit.payload = $urandom;
      rx.in_flit.metadata.req = 5'($urandom);
    end
  endtask

  task automatic send_word(input logic [31:0] w,
                           input logic [4:0] r,
                           input bit clr, output int m);
    m = -1;
    for (int t = 0; t < 200; t++) begin
      tick();
      rx.data_ready = 1'b1;
      rx.in_flit.payload = w;
      rx.in_flit.metadata.req = r;
      rx.err_clr = clr;
      if (rx.accept) begin
        m = cyc;
        break;
      end
    end
    if (m < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: word %0h never taken", w);
    end
  endtask

  task automatic send_pkt(input logic [4:0] r,
                          input logic [6:0] len,
                          input bit bad_dest, input bit corrupt,
                          input int k, input int gap,
                          input bit clr, input bit fixed);
    logic [31:0] hdr, c, w;
    logic [4:0]  dest;
    int          n, m;
    exp_t        e;
    dest = bad_dest ? NODE + 5'd1 : NODE;
    hdr  = {4'($urandom), dest, 16'($urandom), len};
    n    = (len == 7'd0) ? 128 : int'(len);
    c    = m_crc_word(32'hFFFF_FFFF, hdr);
    send_word(hdr, r, clr, m);
    last_hdr_m = m;
    for (int i = 0; i < n; i++) begin
      if (gap > 0 && $urandom_range(99) < gap)
        idle($urandom_range(3, 1));
      w = fixed ? 32'h1111_1111 * (i + 1) : $urandom;
      c = m_crc_word(c, w);
      send_word(w, 5'($urandom), 1'b0, m);
    end
    ovf_left = k;
    send_word(c ^ (corrupt ? 32'h1 : 32'h0),
              5'($urandom), 1'b0, m);
    last_crc_m = m;
    e.due   = m + 1 + k;
    e.vld   = !corrupt;
    e.req   = r;
    e.words = len;
    sb.push_back(e);
    for (int j = 1; j <= k; j++) lowc[m + j] = 1'b1;
  endtask

  initial begin : main
    logic [31:0] c;
    string       s;
    int          m, n_en0, crc_m;
    rx.data_ready = 1'b0;
    rx.overflow   = 1'b0;
    rx.err_clr    = 1'b0;
    rx.in_flit    = '0;
    n_rst         = 1'b0;

    s = "123456789";
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < 9; i++) c = m_crc_byte(c, s[i]);
    chk("model_crc_check", c, 32'h0376_E6E7);

    repeat (3) tick();
    chk("rst_enable", rx.enable, 1'b0);
    chk("rst_crc_valid", rx.crc_valid, 1'b0);
    chk("rst_req", rx.req, 5'd0);
    chk("rst_pkt_words", rx.pkt_words, 7'd0);
    chk("rst_err_dest", rx.err_dest, 1'b0);
    chk("rst_accept", rx.accept, 1'b1);
    tick();
    n_rst = 1'b1;
    checking = 1'b1;
    idle(2);

    send_pkt(5'h0A, 7'd3, 0, 0, 0, 0, 0, 1);
    idle(3);
    chk("good_vld", last_vld, 1'b1);
    chk("good_req", last_req, 5'h0A);
    chk("good_words", last_words, 7'd3);

    send_pkt(5'h0A, 7'd3, 0, 1, 0, 0, 0, 1);
    idle(3);
    chk("corrupt_vld", last_vld, 1'b0);

    send_pkt(5'h07, 7'd2, 0, 0, 4, 0, 0, 0);
    crc_m = last_crc_m;
    send_pkt(5'h19, 7'd1, 0, 0, 0, 0, 0, 0);
    chk("hdr_after_hold", last_hdr_m, crc_m + 5);
    idle(3);
    chk("after_hold_req", last_req, 5'h19);

    send_pkt(5'h11, 7'd0, 0, 0, 0, 0, 0, 0);
    idle(3);
    chk("max_words", last_words, 7'd0);
    chk("max_vld", last_vld, 1'b1);

    send_pkt(5'h02, 7'd6, 0, 0, 0, 40, 0, 0);
    send_pkt(5'h1C, 7'd4, 0, 0, 0, 0, 0, 0);
    idle(3);
    chk("b2b_req", last_req, 5'h1C);

    n_en0 = n_en;
    send_word({4'h0, NODE, 16'h0, 7'd5}, 5'h04, 0, m);
    send_word($urandom, 5'h04, 0, m);
    send_word($urandom, 5'h04, 0, m);
    tick();
    rx.data_ready = 1'b0;
    n_rst = 1'b0;
    tick();
    chk("mid_rst_req", rx.req, 5'd0);
    chk("mid_rst_words", rx.pkt_words, 7'd0);
    n_rst = 1'b1;
    send_pkt(5'h15, 7'd3, 0, 0, 0, 0, 0, 0);
    idle(4);
    chk("enables_after_reset", n_en - n_en0, 1);

    send_pkt(5'h08, 7'd2, 1, 0, 0, 0, 0, 0);
    idle(3);
    chk("err_dest_set", rx.err_dest, 1'b1);
    idle(5);
    chk("err_dest_sticky", rx.err_dest, 1'b1);
    tick();
    rx.err_clr = 1'b1;
    tick();
    chk("err_dest_clr", rx.err_dest, 1'b0);
    send_pkt(5'h09, 7'd2, 1, 0, 0, 0, 1, 0);
    idle(3);
    chk("err_set_wins", rx.err_dest, 1'b1);

    for (int p = 0; p < 16; p++) begin
      send_pkt(5'($urandom), 7'($urandom_range(9, 1)), 0,
               ($urandom_range(3) == 0),
               ($urandom_range(3) == 0) ? $urandom_range(3, 1)
                                        : 0,
               20, 0, 0);
      if ($urandom_range(1) == 0) idle($urandom_range(2));
    end

    for (int t = 0; t < 300; t++) begin
      if (sb.size() == 0) break;
      idle(1);
    end
    chk("drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
